// File: rtl/spike_count_classifier.sv
// Per-neuron spike counter over a programmable window, followed by a sequential
// argmax scan that reports the winning neuron and its count.
module spike_count_classifier #(
    parameter int NUM_NEURONS  = 1,
    parameter int COUNT_WIDTH  = 16,
    parameter int WINDOW_WIDTH = 16,
    parameter int IDX_WIDTH    = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_NEURONS-1:0]  spike_in,
    input  logic                    start,
    input  logic [WINDOW_WIDTH-1:0] window_len,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_WIDTH-1:0]    class_out,
    output logic [COUNT_WIDTH-1:0]  max_count,
    output logic                    no_spike,
    input  logic [IDX_WIDTH-1:0]    rd_idx,
    output logic [COUNT_WIDTH-1:0]  rd_count
);

    typedef enum logic [1:0] {IDLE, RUN, SCAN, DONE} state_t;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [IDX_WIDTH-1:0]   LAST_IDX  = IDX_WIDTH'(NUM_NEURONS - 1);

    state_t                  state;
    state_t                  state_next;
    logic [COUNT_WIDTH-1:0]  counts [NUM_NEURONS];
    logic [WINDOW_WIDTH-1:0] win_len;
    logic [WINDOW_WIDTH-1:0] win_cnt;
    logic [IDX_WIDTH-1:0]    scan_idx;
    logic [IDX_WIDTH-1:0]    best_idx;
    logic [COUNT_WIDTH-1:0]  best_count;
    logic [COUNT_WIDTH-1:0]  scan_count;
    logic                    last_sample;
    logic                    last_scan;

    assign last_sample = (win_cnt == win_len - WINDOW_WIDTH'(1));
    assign last_scan   = (scan_idx == LAST_IDX);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A zero-length window skips RUN entirely and scans the freshly cleared counts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = (window_len == '0) ? SCAN : RUN;
            RUN:     if (last_sample) state_next = SCAN;
            SCAN:    if (last_scan) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == SCAN);
    end

    always_comb begin
        scan_count = '0;
        rd_count   = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (scan_idx == IDX_WIDTH'(i)) scan_count = counts[i];
            if (rd_idx == IDX_WIDTH'(i))   rd_count   = counts[i];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_NEURONS; i++) counts[i] <= '0;
        end else if (state == IDLE && start) begin
            for (int i = 0; i < NUM_NEURONS; i++) counts[i] <= '0;
        end else if (state == RUN) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (spike_in[i] && counts[i] != COUNT_MAX) counts[i] <= counts[i] + 1'b1;
            end
        end
    end

    // Strict greater-than in SCAN keeps the lowest index on ties, including saturated counts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            win_len    <= '0;
            win_cnt    <= '0;
            scan_idx   <= '0;
            best_idx   <= '0;
            best_count <= '0;
            class_out  <= '0;
            max_count  <= '0;
            no_spike   <= 1'b1;
            done       <= 1'b0;
        end else begin
            done <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        win_len    <= window_len;
                        win_cnt    <= '0;
                        scan_idx   <= '0;
                        best_idx   <= '0;
                        best_count <= '0;
                        class_out  <= '0;
                        max_count  <= '0;
                        no_spike   <= 1'b1;
                    end
                end
                RUN: begin
                    win_cnt <= win_cnt + WINDOW_WIDTH'(1);
                end
                SCAN: begin
                    if (scan_count > best_count) begin
                        best_count <= scan_count;
                        best_idx   <= scan_idx;
                    end
                    scan_idx <= scan_idx + IDX_WIDTH'(1);
                end
                DONE: begin
                    class_out <= best_idx;
                    max_count <= best_count;
                    no_spike  <= (best_count == '0);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_count_classifier.sv
// Bench for spike_count_classifier: a timeline model of window/scan timing plus
// directed windows with hand-computed results.
module tb_spike_count_classifier;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int WW   = 16;
    localparam int IW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  spike_in = '0;
    logic          start = 1'b0;
    logic [WW-1:0] window_len = '0;
    logic          busy;
    logic          done;
    logic [IW-1:0] class_out;
    logic [CW-1:0] max_count;
    logic          no_spike;
    logic [IW-1:0] rd_idx = '0;
    logic [CW-1:0] rd_count;

    int tests_run = 0;
    int tests_failed = 0;

    spike_count_classifier #(
        .NUM_NEURONS(N), .COUNT_WIDTH(CW), .WINDOW_WIDTH(WW), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst(rst), .spike_in(spike_in), .start(start),
        .window_len(window_len), .busy(busy), .done(done), .class_out(class_out),
        .max_count(max_count), .no_spike(no_spike), .rd_idx(rd_idx), .rd_count(rd_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: window k+1..k+W accumulates, result and done appear after edge k+W+N+1.
    int cyc = 0;
    int m_cnt [N];
    bit m_started = 0;
    int m_k = 0, m_w = 0, m_done_edge = -1, m_idle_from = 0;
    int exp_class = 0, exp_max = 0, exp_ns = 1;
    bit ns_valid = 1, exp_done = 0, exp_busy = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst) begin
            foreach (m_cnt[j]) m_cnt[j] = 0;
            m_started = 0; m_done_edge = -1; m_idle_from = 0;
            exp_class = 0; exp_max = 0; exp_ns = 1; ns_valid = 1;
            exp_done = 0; exp_busy = 0;
        end else begin
            if (m_started && cyc >= m_k + 1 && cyc <= m_k + m_w) begin
                for (int j = 0; j < N; j++)
                    if (spike_in[j]) m_cnt[j] = (m_cnt[j] >= CMAX) ? CMAX : m_cnt[j] + 1;
            end
            if (cyc == m_done_edge) begin
                int mx;
                mx = 0;
                foreach (m_cnt[j]) if (m_cnt[j] > mx) mx = m_cnt[j];
                exp_class = 0;
                for (int j = N - 1; j >= 0; j--) if (m_cnt[j] == mx) exp_class = j;
                exp_max = mx; exp_ns = (mx == 0); ns_valid = 1;
            end
            if (cyc >= m_idle_from && start) begin
                m_started = 1; m_k = cyc; m_w = int'(window_len);
                foreach (m_cnt[j]) m_cnt[j] = 0;
                exp_class = 0; exp_max = 0; ns_valid = 0;
                m_done_edge = cyc + m_w + N + 1;
                m_idle_from = cyc + m_w + N + 2;
            end
            exp_done = (cyc == m_done_edge);
            exp_busy = m_started && cyc >= m_k && cyc <= m_k + m_w + N - 1;
        end
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            checkOutput("busy", busy, exp_busy);
            checkOutput("done", done, exp_done);
            checkOutput("class_out", class_out, exp_class);
            checkOutput("max_count", max_count, exp_max);
            checkOutput("rd_count", rd_count, (int'(rd_idx) < N) ? m_cnt[rd_idx] : 0);
            if (ns_valid) checkOutput("no_spike", no_spike, exp_ns);
        end
    end

    // Runs one window alternating pat_a/pat_b per sample; returns cycles from start edge to done.
    task automatic applyStimulus(input int w, input logic [N-1:0] pat_a, input logic [N-1:0] pat_b,
                                 input bit mid_start, output int latency);
        int k;
        @(posedge clk); #1;
        start = 1'b1; window_len = WW'(w); spike_in = '1;
        @(posedge clk); #1;
        k = cyc; start = 1'b0;
        for (int i = 0; i < w; i++) begin
            spike_in = (i % 2 == 0) ? pat_a : pat_b;
            if (mid_start && i == 2) begin
                start = 1'b1; window_len = WW'(3);
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; spike_in = '1;
        latency = -1;
        for (int c = 0; c < 200 && latency < 0; c++) begin
            @(negedge clk);
            if (done === 1'b1) latency = cyc - k;
        end
        if (latency < 0) checkOutput("done_timeout", 0, 1);
        spike_in = '0;
    endtask

    task automatic checkResult(input string name, input int lat, input int exp_lat,
                               input int cls, input int mx, input int ns);
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_class"}, class_out, cls);
        checkOutput({name, "_max"}, max_count, mx);
        checkOutput({name, "_nospike"}, no_spike, ns);
    endtask

    initial begin
        int lat;
        int done_seen;
        int tie_exp [5];
        tie_exp = '{5, 5, 5, 5, 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_class", class_out, 0);
        checkOutput("reset_max", max_count, 0);
        checkOutput("reset_nospike", no_spike, 1);
        rst = 1'b1;

        rd_idx = 2;
        applyStimulus(10, 4'b0100, 4'b0100, 0, lat);
        checkResult("single", lat, 15, 2, 10, 0);

        rd_idx = 1;
        applyStimulus(5, 4'b1111, 4'b1111, 0, lat);
        checkResult("tie", lat, 10, 0, 5, 0);
        for (int i = 0; i < 5; i++) begin
            rd_idx = IW'(i); #1;
            checkOutput("tie_readback", rd_count, tie_exp[i]);
        end

        rd_idx = 1;
        applyStimulus(40, 4'b0010, 4'b0010, 0, lat);
        checkResult("saturate", lat, 45, 1, 15, 0);

        applyStimulus(20, 4'b0110, 4'b0110, 0, lat);
        checkResult("sat_tie", lat, 25, 1, 15, 0);

        applyStimulus(0, 4'b1111, 4'b1111, 0, lat);
        checkResult("zero_window", lat, 5, 0, 0, 1);

        rd_idx = 3;
        applyStimulus(6, 4'b0000, 4'b0000, 0, lat);
        checkResult("no_spikes", lat, 11, 0, 0, 1);

        applyStimulus(7, 4'b1000, 4'b1100, 0, lat);
        checkResult("alternate", lat, 12, 3, 7, 0);

        rd_idx = 0;
        applyStimulus(8, 4'b0001, 4'b0001, 1, lat);
        checkResult("mid_start", lat, 13, 0, 8, 0);

        rd_idx = 2;
        @(posedge clk); #1;
        start = 1'b1; window_len = WW'(10); spike_in = 4'b0100;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_count", rd_count, 0);
        done_seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        spike_in = '0;

        rd_idx = 1;
        applyStimulus(3, 4'b0010, 4'b1010, 0, lat);
        checkResult("after_abort", lat, 8, 1, 3, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
